// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types for the March C- MBIST sequencer.
// Holds the FSM state enum, the March element table and pipeline constants.
package mbist_pkg;

   localparam logic [2:0] MARCH_LAST_ELEM = 3'd5;
   localparam int         RD_LATENCY      = 2;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_PRE   = 4'd1,
      ST_M0    = 4'd2,
      ST_M1    = 4'd3,
      ST_M2    = 4'd4,
      ST_M3    = 4'd5,
      ST_M4    = 4'd6,
      ST_M5    = 4'd7,
      ST_DRAIN = 4'd8,
      ST_DONE  = 4'd9
   } state_t;

   // two_op elements are (read, write); single-op elements are a write
   // when wr_only is set, else a read.
   typedef struct packed {
      logic dir_dn;
      logic two_op;
      logic wr_only;
      logic rval;
      logic wval;
   } march_elem_t;

   localparam march_elem_t ME_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam march_elem_t ME_M0   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam march_elem_t ME_M1   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam march_elem_t ME_M2   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam march_elem_t ME_M3   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam march_elem_t ME_M4   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam march_elem_t ME_M5   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   // Indices 6 and 7 are padding so non-March states map to a no-op.
   localparam march_elem_t [7:0] MARCH_TBL = {
      ME_NONE, ME_NONE, ME_M5, ME_M4,
      ME_M3,   ME_M2,   ME_M1, ME_M0
   };

   function automatic logic [2:0] state_elem(input state_t i_state);
      return 3'(4'(i_state) - 4'(ST_M0));
   endfunction

   function automatic state_t elem_state(input logic [2:0] i_elem);
      return state_t'(4'(i_elem) + 4'(ST_M0));
   endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// mbist_cmp_pipe: read-latency-matched compare pipeline with sticky fail.
// Ports: i_push/i_exp/i_addr/i_elem enter a read; i_rdata is compared
// RD_LATENCY cycles later; o_fail is sticky, o_fail_addr/o_fail_elem hold
// the first miscompare and o_fail_count saturates at 255 (diag outputs
// exist only when MBIST_DIAG_EN is defined, else they are tied to 0).
module mbist_cmp_pipe
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clear,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_exp,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [2:0]            i_elem,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  o_fail,
   output logic [ADDR_WIDTH-1:0] o_fail_addr,
   output logic [2:0]            o_fail_elem,
   output logic [7:0]            o_fail_count
);

   logic [RD_LATENCY-1:0] r_vld;
   logic [DATA_WIDTH-1:0] r_exp [RD_LATENCY];
   logic                  r_fail;
   logic                  w_miss;

   assign w_miss = r_vld[RD_LATENCY-1] &&
                   (i_rdata != r_exp[RD_LATENCY-1]);
   assign o_fail = r_fail;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_vld  <= '0;
         r_fail <= 1'b0;
      end else begin
         r_vld <= {r_vld[RD_LATENCY-2:0], i_push};
         if (w_miss)
            r_fail <= 1'b1;
      end
   end

   // Data stages need no reset: r_vld qualifies them.
   always_ff @(posedge clk) begin
      r_exp[0] <= i_exp;
      for (int i = 1; i < RD_LATENCY; i++)
         r_exp[i] <= r_exp[i-1];
   end

`ifdef MBIST_DIAG_EN
   logic [ADDR_WIDTH-1:0] r_addr [RD_LATENCY];
   logic [2:0]            r_elem [RD_LATENCY];
   logic [ADDR_WIDTH-1:0] r_fail_addr;
   logic [2:0]            r_fail_elem;
   logic [7:0]            r_fail_count;

   always_ff @(posedge clk) begin
      r_addr[0] <= i_addr;
      r_elem[0] <= i_elem;
      for (int i = 1; i < RD_LATENCY; i++) begin
         r_addr[i] <= r_addr[i-1];
         r_elem[i] <= r_elem[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_fail_addr  <= '0;
         r_fail_elem  <= '0;
         r_fail_count <= '0;
      end else if (w_miss) begin
         // r_fail still low means this is the first miscompare
         if (!r_fail) begin
            r_fail_addr <= r_addr[RD_LATENCY-1];
            r_fail_elem <= r_elem[RD_LATENCY-1];
         end
         if (r_fail_count != 8'hFF)
            r_fail_count <= r_fail_count + 8'd1;
      end
   end

   assign o_fail_addr  = r_fail_addr;
   assign o_fail_elem  = r_fail_elem;
   assign o_fail_count = r_fail_count;
`else
   logic w_unused_diag;

   assign w_unused_diag = ^{i_addr, i_elem};
   assign o_fail_addr   = '0;
   assign o_fail_elem   = '0;
   assign o_fail_count  = '0;
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- MBIST sequencer for one fault_mem instance.
// Ports: clk/rst (sync, active high), start -> busy/done/fail handshake;
// mem_write_read/mem_address/mem_wdata/mem_rdata drive the memory, with
// mem_wdata one cycle ahead of its write; fail_addr/fail_elem/fail_count
// are diagnostics built only when MBIST_DIAG_EN is defined.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CAPACITY   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic                  mem_write_read,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic [7:0]            fail_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
      ADDR_WIDTH'(CAPACITY - 1);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_phase;
   logic                  r_drain;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_rd;
   logic [DATA_WIDTH-1:0] r_exp;
   logic [2:0]            r_elem;

   state_t                w_nstate;
   logic [ADDR_WIDTH-1:0] w_naddr;
   logic                  w_nphase;
   logic                  w_start;
   logic [2:0]            w_elem;
   logic [2:0]            w_adv;
   logic [2:0]            w_nelem;
   logic                  w_last_op;
   logic                  w_last_addr;
   logic                  w_nop;
   logic                  w_nwe;

   always_comb begin
      w_elem      = state_elem(r_state);
      w_adv       = w_elem + 3'd1;
      w_last_op   = !MARCH_TBL[w_elem].two_op || r_phase;
      w_last_addr = MARCH_TBL[w_elem].dir_dn ? (r_addr == '0)
                                             : (r_addr == LAST_ADDR);
      w_nstate    = r_state;
      w_naddr     = r_addr;
      w_nphase    = 1'b0;
      w_start     = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_nstate = ST_PRE;
               w_naddr  = '0;
               w_start  = 1'b1;
            end
         end
         ST_PRE: begin
            w_nstate = ST_M0;
            w_naddr  = '0;
         end
         ST_DRAIN: begin
            if (r_drain)
               w_nstate = ST_DONE;
         end
         default: begin
            if (!w_last_op)
               w_nphase = 1'b1;
            else if (!w_last_addr)
               w_naddr = MARCH_TBL[w_elem].dir_dn
                       ? r_addr - ADDR_WIDTH'(1)
                       : r_addr + ADDR_WIDTH'(1);
            else if (w_elem == MARCH_LAST_ELEM)
               w_nstate = ST_DRAIN;
            else begin
               w_nstate = elem_state(w_adv);
               w_naddr  = MARCH_TBL[w_adv].dir_dn ? LAST_ADDR : '0;
            end
         end
      endcase
      w_nelem = state_elem(w_nstate);
      w_nop   = (w_nstate >= ST_M0) && (w_nstate <= ST_M5);
      w_nwe   = w_nop && (MARCH_TBL[w_nelem].two_op
                          ? w_nphase
                          : MARCH_TBL[w_nelem].wr_only);
   end

   // Outputs are registered from the next-state decode so that each
   // op cycle presents its command straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_phase <= 1'b0;
         r_drain <= 1'b0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rd    <= 1'b0;
         r_exp   <= '0;
         r_elem  <= '0;
      end else begin
         r_state <= w_nstate;
         r_addr  <= w_naddr;
         r_phase <= w_nphase;
         r_drain <= (r_state == ST_DRAIN);
         r_we    <= w_nwe;
         r_rd    <= w_nop && !w_nwe;
         r_exp   <= {DATA_WIDTH{MARCH_TBL[w_nelem].rval}};
         r_elem  <= w_nelem;
         r_busy  <= (w_nstate != ST_IDLE) && (w_nstate != ST_DONE);
         r_done  <= (w_nstate == ST_DONE);
         // wdata looks one cycle ahead: it carries the background of
         // the element about to run, and holds through read-only ones.
         if (w_start)
            r_wdata <= {DATA_WIDTH{MARCH_TBL[0].wval}};
         else if (w_nop && (MARCH_TBL[w_nelem].two_op ||
                            MARCH_TBL[w_nelem].wr_only))
            r_wdata <= {DATA_WIDTH{MARCH_TBL[w_nelem].wval}};
      end
   end

   mbist_cmp_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_cmp (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_start),
      .i_push       (r_rd),
      .i_exp        (r_exp),
      .i_addr       (r_addr),
      .i_elem       (r_elem),
      .i_rdata      (mem_rdata),
      .o_fail       (fail),
      .o_fail_addr  (fail_addr),
      .o_fail_elem  (fail_elem),
      .o_fail_count (fail_count)
   );

   assign busy           = r_busy;
   assign done           = r_done;
   assign mem_write_read = r_we;
   assign mem_address    = r_addr;
   assign mem_wdata      = r_wdata;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: randomized bench for the March C- sequencer.
// A memory model with injectable stuck-at faults sits behind the DUT.
module tb_mbist_march_ctrl;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int CAP = 16;
   localparam int TOT = 10 * CAP + 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, fail, mem_we;
   logic [AW-1:0] mem_addr, fail_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [2:0]    fail_elem;
   logic [7:0]    fail_count;

   always #5 clk = ~clk;

   mbist_march_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CAPACITY   (CAP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .fail           (fail),
      .mem_write_read (mem_we),
      .mem_address    (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .fail_addr      (fail_addr),
      .fail_elem      (fail_elem),
      .fail_count     (fail_count)
   );

   // fault_mem behaviour: registered wdata, 2-cycle read latency
   bit            f_en = 1'b0;
   int            f_addr = 0;
   logic [DW-1:0] f_mask = '0;
   bit            f_val = 1'b0;
   logic [DW-1:0] mem [CAP];
   logic [DW-1:0] m_wd, m_rd1;

   function automatic logic [DW-1:0] faulty(input logic [DW-1:0] d,
                                            input int a);
      if (f_en && a == f_addr)
         return f_val ? (d | f_mask) : (d & ~f_mask);
      return d;
   endfunction

   always @(posedge clk) begin
      m_wd <= mem_wdata;
      if (mem_we)
         mem[mem_addr] <= m_wd;
      m_rd1     <= faulty(mem[mem_addr], int'(mem_addr));
      mem_rdata <= m_rd1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {1'b0, busy, done, fail, mem_we, mem_addr, mem_wdata,
              fail_addr, fail_elem, fail_count};
   endfunction

   // Reference op list for March C-, one entry per op cycle
   bit            q_we [$];
   int            q_addr [$];
   logic [DW-1:0] q_dat [$];
   int            q_elem [$];

   function automatic void push(input bit w, input int a, input bit v,
                                input int e);
      q_we.push_back(w);
      q_addr.push_back(a);
      q_dat.push_back({DW{v}});
      q_elem.push_back(e);
   endfunction

   function automatic void build_ref();
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < CAP; k++) begin
            int a;
            a = (e == 3 || e == 4) ? CAP - 1 - k : k;
            case (e)
               0: push(1, a, 0, e);
               1: begin push(0, a, 0, e); push(1, a, 1, e); end
               2: begin push(0, a, 1, e); push(1, a, 0, e); end
               3: begin push(0, a, 0, e); push(1, a, 1, e); end
               4: begin push(0, a, 1, e); push(1, a, 0, e); end
               default: push(0, a, 0, e);
            endcase
         end
      end
   endfunction

   task automatic predict(output bit pf, output int pc, output int pa,
                          output int pe);
      logic [DW-1:0] m [CAP];
      pf = 1'b0;
      pc = 0;
      pa = 0;
      pe = 0;
      for (int i = 0; i < q_we.size(); i++) begin
         if (q_we[i])
            m[q_addr[i]] = q_dat[i];
         else if (faulty(m[q_addr[i]], q_addr[i]) != q_dat[i]) begin
            if (!pf) begin
               pa = q_addr[i];
               pe = q_elem[i];
            end
            pf = 1'b1;
            if (pc < 255)
               pc++;
         end
      end
   endtask

   task automatic run_march(input bit hold, input string tag);
      int            seq_err, wd_err, nbusy, done_c, idx;
      logic [DW-1:0] prev_wd;
      bit            pf;
      int            pc, pa, pe;
      predict(pf, pc, pa, pe);
`ifndef MBIST_DIAG_EN
      pc = 0;
      pa = 0;
      pe = 0;
`endif
      seq_err = 0;
      wd_err  = 0;
      nbusy   = 0;
      done_c  = 0;
      start   = 1'b1;
      prev_wd = mem_wdata;
      for (int c = 1; c <= TOT; c++) begin
         @(negedge clk);
         if (!hold)
            start = 1'b0;
         if (busy)
            nbusy++;
         if (done && done_c == 0)
            done_c = c;
         if (c == 1)
            check({tag, ".pre"}, {busy, done, mem_we}, 3'b100);
         if (c == 2)
            check({tag, ".first_wr"}, {mem_we, mem_addr, prev_wd},
                  {1'b1, 4'd0, 8'h00});
         if (c >= 2 && c <= TOT - 3) begin
            idx = c - 2;
            if (mem_we !== q_we[idx] || int'(mem_addr) !== q_addr[idx])
               seq_err++;
            if (q_we[idx] && prev_wd !== q_dat[idx])
               wd_err++;
         end else if (c > TOT - 3 && c < TOT) begin
            if (mem_we !== 1'b0 || busy !== 1'b1)
               seq_err++;
         end
         prev_wd = mem_wdata;
      end
      check({tag, ".seq"}, seq_err, 0);
      check({tag, ".wdata"}, wd_err, 0);
      check({tag, ".busy_cyc"}, nbusy, TOT - 1);
      check({tag, ".done_cyc"}, done_c, TOT);
      check({tag, ".fail"}, fail, pf);
      check({tag, ".fail_addr"}, fail_addr, pa);
      check({tag, ".fail_elem"}, fail_elem, pe);
      check({tag, ".fail_count"}, fail_count, pc);
      @(negedge clk);
      if (hold)
         check({tag, ".restart"}, {busy, done}, 2'b10);
      else
         check({tag, ".done_hold"}, {busy, done}, 2'b01);
   endtask

   initial begin
      int k;
      build_ref();
      repeat (3) @(negedge clk);
      check("reset_outs", outs(), 0);
      rst = 1'b0;
      @(negedge clk);

      run_march(0, "clean");

      f_en   = 1'b1;
      f_addr = 5;
      f_mask = 8'h01;
      f_val  = 1'b1;
      run_march(0, "sa1_a5b0");

      for (int r = 0; r < 6; r++) begin
         f_en   = ($urandom_range(0, 3) != 0);
         f_addr = $urandom_range(0, CAP - 1);
         f_mask = DW'(1) << $urandom_range(0, DW - 1);
         f_val  = 1'(($urandom_range(0, 1)));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         run_march(0, $sformatf("rnd%0d", r));
      end

      // abort somewhere inside M3, then a clean run from IDLE
      f_en  = 1'b0;
      k     = $urandom_range(5 * CAP + 2, 7 * CAP + 1);
      start = 1'b1;
      for (int c = 1; c <= k; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_outs", outs(), 0);
      rst = 1'b0;
      @(negedge clk);
      run_march(0, "post_abort");

      run_march(1, "held_start");
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
